// File: rtl/round_sequencer.sv
// round_sequencer: multi-round session controller for the letter-reaction game.
// Draws goal letters, gates the stopwatch, judges each key press as hit, miss
// or timeout, and keeps per-session score plus the best reaction time.
// Optional feature macro: ROUND_SEQ_STREAK_EN (longest-hit-run tracking).
module round_sequencer #(
  parameter int ROUNDS      = 8,
  parameter int NUM_LETTERS = 26,
  parameter int KEYUP_CODE  = 21,
  parameter int TIMEOUT_S   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_code,
  input  logic [4:0] rand_in,
  input  logic [3:0] t_s,
  input  logic [3:0] t_ms,
  input  logic [3:0] t_mms,
  output logic [1:0] timer_ctl,
  output logic [4:0] goal_letter,
  output logic [1:0] disp_sel,
  output logic [3:0] round_num,
  output logic [3:0] hits,
  output logic [3:0] misses,
  output logic [3:0] best_s,
  output logic [3:0] best_ms,
  output logic [3:0] best_mms,
  output logic [3:0] streak_max,
  output logic       session_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DRAW = 3'd1,
    PLAY = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [4:0]  KEYUP      = 5'(KEYUP_CODE);
  localparam logic [5:0]  LETTER_LIM = 6'(NUM_LETTERS);
  localparam logic [3:0]  TIMEOUT    = 4'(TIMEOUT_S);
  localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [11:0] BEST_INIT  = 12'h999;

  state_t      state_reg, state_next;
  logic [4:0]  prev_code_reg;
  logic [1:0]  timer_ctl_reg, timer_ctl_next;
  logic [4:0]  goal_reg, goal_next;
  logic [1:0]  disp_reg, disp_next;
  logic [3:0]  round_reg, round_next;
  logic [3:0]  hits_reg, hits_next;
  logic [3:0]  misses_reg, misses_next;
  logic [11:0] best_reg, best_next;
  logic        done_reg, done_next;

  logic        key_ev, keyup_ev, press_ev;
  logic        hit, miss, clear_session;
  logic [11:0] now_time;

  assign key_ev   = (key_code != prev_code_reg);
  assign keyup_ev = key_ev && (key_code == KEYUP);
  assign press_ev = key_ev && (key_code != KEYUP);
  assign now_time = {t_s, t_ms, t_mms};

  // Next-state, judging and registered-output values derived from the next state
  always_comb begin
    state_next    = state_reg;
    goal_next     = goal_reg;
    round_next    = round_reg;
    hits_next     = hits_reg;
    misses_next   = misses_reg;
    best_next     = best_reg;
    hit           = 1'b0;
    miss          = 1'b0;
    clear_session = 1'b0;

    case (state_reg)
      IDLE: begin
        if (keyup_ev) state_next = DRAW;
      end
      DRAW: begin
        // Keyup is never a legal goal, so reject it along with out-of-range codes
        if (({1'b0, rand_in} < LETTER_LIM) && (rand_in != KEYUP)) begin
          goal_next  = rand_in;
          state_next = PLAY;
        end
      end
      PLAY: begin
        // A real key press takes priority over a timeout in the same cycle
        if (press_ev) begin
          if (key_code == goal_reg) hit = 1'b1;
          else                      miss = 1'b1;
        end else if (t_s >= TIMEOUT) begin
          miss = 1'b1;
        end
        if (hit) begin
          hits_next = hits_reg + 4'd1;
          if (now_time < best_reg) best_next = now_time;
          state_next = GAP;
        end
        if (miss) begin
          misses_next = misses_reg + 4'd1;
          state_next  = GAP;
        end
      end
      GAP: begin
        if (keyup_ev) begin
          if (round_reg == LAST_ROUND) begin
            state_next = DONE;
          end else begin
            round_next = round_reg + 4'd1;
            state_next = DRAW;
          end
        end
      end
      DONE: begin
        if (keyup_ev) begin
          clear_session = 1'b1;
          round_next    = 4'd0;
          hits_next     = 4'd0;
          misses_next   = 4'd0;
          state_next    = DRAW;
        end
      end
      default: state_next = IDLE;
    endcase

    timer_ctl_next = 2'b00;
    disp_next      = 2'd1;
    case (state_next)
      IDLE, DRAW: timer_ctl_next = 2'b01;
      PLAY:       timer_ctl_next = 2'b10;
      default:    timer_ctl_next = 2'b00;
    endcase
    case (state_next)
      // GAP keeps whichever result screen was chosen on entry
      GAP:     disp_next = hit ? 2'd0 : (miss ? 2'd2 : disp_reg);
      DONE:    disp_next = 2'd3;
      default: disp_next = 2'd1;
    endcase
    done_next = (state_next == DONE);
  end

  // Main state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      prev_code_reg <= KEYUP;
      timer_ctl_reg <= 2'b01;
      goal_reg      <= 5'd0;
      disp_reg      <= 2'd1;
      round_reg     <= 4'd0;
      hits_reg      <= 4'd0;
      misses_reg    <= 4'd0;
      best_reg      <= BEST_INIT;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_code_reg <= key_code;
      timer_ctl_reg <= timer_ctl_next;
      goal_reg      <= goal_next;
      disp_reg      <= disp_next;
      round_reg     <= round_next;
      hits_reg      <= hits_next;
      misses_reg    <= misses_next;
      best_reg      <= best_next;
      done_reg      <= done_next;
    end
  end

`ifdef ROUND_SEQ_STREAK_EN
  logic [3:0] run_reg, run_next;
  logic [3:0] smax_reg, smax_next;
  logic [3:0] run_inc;

  assign run_inc = run_reg + 4'd1;

  // Current hit run and its session maximum
  always_comb begin
    run_next  = run_reg;
    smax_next = smax_reg;
    if (clear_session) begin
      run_next  = 4'd0;
      smax_next = 4'd0;
    end else if (hit) begin
      run_next = run_inc;
      if (run_inc > smax_reg) smax_next = run_inc;
    end else if (miss) begin
      run_next = 4'd0;
    end
  end

  // Streak registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg  <= 4'd0;
      smax_reg <= 4'd0;
    end else begin
      run_reg  <= run_next;
      smax_reg <= smax_next;
    end
  end

  assign streak_max = smax_reg;
`else
  assign streak_max = 4'd0;
`endif

  assign timer_ctl    = timer_ctl_reg;
  assign goal_letter  = goal_reg;
  assign disp_sel     = disp_reg;
  assign round_num    = round_reg;
  assign hits         = hits_reg;
  assign misses       = misses_reg;
  assign best_s       = best_reg[11:8];
  assign best_ms      = best_reg[7:4];
  assign best_mms     = best_reg[3:0];
  assign session_done = done_reg;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: scoreboard bench for round_sequencer with ROUNDS = 2.
// Each scenario pushes the expected output snapshot before clocking and pops
// it for comparison once the DUT has produced the response.
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] key_code, rand_in;
  logic [3:0] t_s, t_ms, t_mms;
  logic [1:0] timer_ctl, disp_sel;
  logic [4:0] goal_letter;
  logic [3:0] round_num, hits, misses, best_s, best_ms, best_mms, streak_max;
  logic       session_done;

  typedef struct packed {
    logic [1:0]  ctl;
    logic [4:0]  goal;
    logic [1:0]  disp;
    logic [3:0]  rnd;
    logic [3:0]  hits;
    logic [3:0]  misses;
    logic [11:0] best;
    logic [3:0]  streak;
    logic        done;
  } snap_t;

`ifdef ROUND_SEQ_STREAK_EN
  localparam logic [3:0] S1 = 4'd1;
`else
  localparam logic [3:0] S1 = 4'd0;
`endif

  localparam snap_t RESET_SNAP = '{ctl: 2'b01, goal: 5'd0, disp: 2'd1, rnd: 4'd0,
                                   hits: 4'd0, misses: 4'd0, best: 12'h999,
                                   streak: 4'd0, done: 1'b0};

  snap_t sb[$];
  snap_t e, got, exp;
  int    errors = 0;
  int    checks = 0;

  round_sequencer #(.ROUNDS(2), .NUM_LETTERS(26), .KEYUP_CODE(21), .TIMEOUT_S(5)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .rand_in(rand_in),
    .t_s(t_s), .t_ms(t_ms), .t_mms(t_mms), .timer_ctl(timer_ctl),
    .goal_letter(goal_letter), .disp_sel(disp_sel), .round_num(round_num),
    .hits(hits), .misses(misses), .best_s(best_s), .best_ms(best_ms),
    .best_mms(best_mms), .streak_max(streak_max), .session_done(session_done)
  );

  always #5 clk = ~clk;

  function automatic snap_t snap();
    return snap_t'({timer_ctl, goal_letter, disp_sel, round_num, hits, misses,
                    best_s, best_ms, best_mms, streak_max, session_done});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_timer(input logic [3:0] s, input logic [3:0] ms, input logic [3:0] mms);
    t_s = s; t_ms = ms; t_mms = mms;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_code = 5'd3; rand_in = 5'd7; set_timer(4'd0, 4'd0, 4'd0);
    sb.push_back(RESET_SNAP);
    tick(); tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_held got=%h exp=%h", got, exp); end
    else $display("txn reset_held ok %h", got);
    rst = 1'b0;
    e = RESET_SNAP;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL idle_press_ignored got=%h exp=%h", got, exp); end
    else $display("txn idle_press_ignored ok %h", got);
  endtask

  task automatic test_first_round();
    key_code = 5'd21;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL idle_keyup_draw got=%h exp=%h", got, exp); end
    else $display("txn idle_keyup_draw ok %h", got);
    e.ctl = 2'b10; e.goal = 5'd7;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL draw_accept_7 got=%h exp=%h", got, exp); end
    else $display("txn draw_accept_7 ok %h", got);
    set_timer(4'd0, 4'd4, 4'd2); key_code = 5'd7;
    e.ctl = 2'b00; e.hits = 4'd1; e.best = 12'h042; e.disp = 2'd0; e.streak = S1;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL hit_best got=%h exp=%h", got, exp); end
    else $display("txn hit_best ok %h", got);
    key_code = 5'd21;
    e.ctl = 2'b01; e.disp = 2'd1; e.rnd = 4'd1;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL gap_next_round got=%h exp=%h", got, exp); end
    else $display("txn gap_next_round ok %h", got);
  endtask

  task automatic test_draw_reject();
    logic [4:0] seq [3];
    seq[0] = 5'd30; seq[1] = 5'd21; seq[2] = 5'd12;
    for (int i = 0; i < 3; i++) begin
      rand_in = seq[i];
      if (i == 2) begin e.ctl = 2'b10; e.goal = 5'd12; end
      sb.push_back(e);
      tick();
      got = snap(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL draw_rand_%0d got=%h exp=%h", seq[i], got, exp); end
      else $display("txn draw_rand_%0d ok %h", seq[i], got);
    end
  endtask

  task automatic test_timeout();
    set_timer(4'd4, 4'd9, 4'd9);
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL play_below_timeout got=%h exp=%h", got, exp); end
    else $display("txn play_below_timeout ok %h", got);
    set_timer(4'd5, 4'd0, 4'd0);
    e.ctl = 2'b00; e.misses = 4'd1; e.disp = 2'd2;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_miss got=%h exp=%h", got, exp); end
    else $display("txn timeout_miss ok %h", got);
    set_timer(4'd0, 4'd0, 4'd0); key_code = 5'd3;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL gap_press_hold got=%h exp=%h", got, exp); end
    else $display("txn gap_press_hold ok %h", got);
    key_code = 5'd21;
    e.disp = 2'd3; e.done = 1'b1;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL done_entry got=%h exp=%h", got, exp); end
    else $display("txn done_entry ok %h", got);
  endtask

  task automatic test_back_to_back();
    key_code = 5'd3;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL done_press_hold got=%h exp=%h", got, exp); end
    else $display("txn done_press_hold ok %h", got);
    key_code = 5'd21; rand_in = 5'd9;
    e.ctl = 2'b01; e.disp = 2'd1; e.done = 1'b0; e.rnd = 4'd0;
    e.hits = 4'd0; e.misses = 4'd0; e.streak = 4'd0;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL done_exit_clear got=%h exp=%h", got, exp); end
    else $display("txn done_exit_clear ok %h", got);
    e.ctl = 2'b10; e.goal = 5'd9;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL draw_accept_9 got=%h exp=%h", got, exp); end
    else $display("txn draw_accept_9 ok %h", got);
    set_timer(4'd5, 4'd0, 4'd0); key_code = 5'd9;
    e.ctl = 2'b00; e.hits = 4'd1; e.disp = 2'd0; e.streak = S1;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout_and_key_hit got=%h exp=%h", got, exp); end
    else $display("txn timeout_and_key_hit ok %h", got);
    set_timer(4'd0, 4'd0, 4'd0); key_code = 5'd21;
    e.ctl = 2'b01; e.disp = 2'd1; e.rnd = 4'd1;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL gap_next_round2 got=%h exp=%h", got, exp); end
    else $display("txn gap_next_round2 ok %h", got);
    e.ctl = 2'b10;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL draw_accept_9b got=%h exp=%h", got, exp); end
    else $display("txn draw_accept_9b ok %h", got);
    key_code = 5'd4;
    e.ctl = 2'b00; e.misses = 4'd1; e.disp = 2'd2;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wrong_key_miss got=%h exp=%h", got, exp); end
    else $display("txn wrong_key_miss ok %h", got);
    key_code = 5'd21;
    e.disp = 2'd3; e.done = 1'b1;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL session_done got=%h exp=%h", got, exp); end
    else $display("txn session_done ok %h", got);
  endtask

  task automatic test_async_reset();
    key_code = 5'd3;
    sb.push_back(e);
    tick();
    key_code = 5'd21; rand_in = 5'd5;
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL done_press_hold2 got=%h exp=%h", got, exp); end
    else $display("txn done_press_hold2 ok %h", got);
    e.ctl = 2'b01; e.disp = 2'd1; e.done = 1'b0; e.rnd = 4'd0;
    e.hits = 4'd0; e.misses = 4'd0; e.streak = 4'd0;
    tick();
    e.ctl = 2'b10; e.goal = 5'd5;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL draw_accept_5 got=%h exp=%h", got, exp); end
    else $display("txn draw_accept_5 ok %h", got);
    set_timer(4'd0, 4'd4, 4'd1); key_code = 5'd5;
    e.ctl = 2'b00; e.hits = 4'd1; e.best = 12'h041; e.disp = 2'd0; e.streak = S1;
    sb.push_back(e);
    tick();
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL hit_better_best got=%h exp=%h", got, exp); end
    else $display("txn hit_better_best ok %h", got);
    set_timer(4'd0, 4'd0, 4'd0); key_code = 5'd21;
    tick(); tick();
    e.ctl = 2'b10; e.disp = 2'd1; e.rnd = 4'd1;
    sb.push_back(e);
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL play_round1 got=%h exp=%h", got, exp); end
    else $display("txn play_round1 ok %h", got);
    #2 rst = 1'b1;
    #2;
    sb.push_back(RESET_SNAP);
    got = snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
    else $display("txn async_reset ok %h", got);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_draw_reject();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Multi-round session controller for the letter-reaction game. Sits between the keyboard wrapper, random-letter LFSR, stopwatch timer and display multiplexer. It draws goal letters, gates the timer, judges each key press as hit, miss or timeout, and keeps per-session score and best reaction time. It also selects which display source the mux shows.

## Interface
Parameters:
- ROUNDS, 8: rounds per session (1..15).
- NUM_LETTERS, 26: valid goal codes are 0..NUM_LETTERS-1.
- KEYUP_CODE, 21: keyboard code meaning "key released"; never a goal.
- TIMEOUT_S, 5: PLAY ends as a miss once timer seconds digit ≥ this value.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- key_code  in  5  current code from keyboard wrapper; a change versus previous cycle is a key event.
- rand_in  in  5  free-running LFSR output.
- t_s, t_ms, t_mms  in  4 each  timer BCD digits (seconds, 1/10 s, 1/100 s).
- timer_ctl  out  2  bit1 = enable, bit0 = reset.
- goal_letter  out  5  current goal code.
- disp_sel  out  2  0 = time, 1 = goal, 2 = loss, 3 = summary.
- round_num  out  4  zero-based current round.
- hits, misses  out  4 each  session counters.
- best_s, best_ms, best_mms  out  4 each  best hit time, BCD.
- streak_max  out  4  longest hit run (see Configuration).
- session_done  out  1  high in DONE.

## Operation
- Key event: key_code ≠ registered previous code. Keyup event: key event whose new code is KEYUP_CODE. The previous-code register resets to KEYUP_CODE.
- States are IDLE, DRAW, PLAY, GAP, DONE.
- IDLE:
  - timer_ctl = 01, disp_sel = 1.
  - Keyup event → DRAW.
- DRAW:
  - timer_ctl = 01.
  - Each cycle, rand_in is accepted if < NUM_LETTERS and ≠ KEYUP_CODE.
  - On accept: latch goal_letter → PLAY. Otherwise stay and resample next cycle.
- PLAY:
  - timer_ctl = 10, disp_sel = 1. Keyup events are ignored.
  - Non-keyup event with code = goal_letter: hit.
    - hits+1, disp_sel = 0.
    - If {t_s,t_ms,t_mms} < best (BCD lexicographic, strict), best updates.
    - → GAP.
  - Non-keyup event with any other code: miss.
    - misses+1, disp_sel = 2 → GAP.
  - No event and t_s ≥ TIMEOUT_S: timeout miss, same actions as a miss.
  - Key event and timeout in the same cycle: the key event wins.
- GAP:
  - timer_ctl = 00; timer digits stay frozen for display.
  - Keyup event: if round_num = ROUNDS-1 → DONE, otherwise round_num+1 → DRAW.
  - After a timeout, the player must press and release any key to advance.
- DONE:
  - session_done = 1, disp_sel = 3, timer_ctl = 00.
  - Keyup event clears round_num, hits, misses and streak counters → DRAW.
  - Best time is kept across sessions; only rst restores it.
- hits + misses never exceeds ROUNDS, so 4-bit counters never wrap.

## Timing
- All outputs are registered. State, timer_ctl, disp_sel and counters change on the same clk edge that samples the causing event.
- Latency: 1 cycle from key_code change to the new state or timer_ctl.
- DRAW lasts at least 1 cycle, so the timer is reset for at least 1 cycle before enable.
- Reset values: state IDLE, timer_ctl 01, goal_letter 0, disp_sel 1, round_num 0, hits 0, misses 0, best 9/9/9, streak_max 0, session_done 0.
- rst asserted mid-round aborts immediately; best time is lost.

## Configuration
- ROUND_SEQ_STREAK_EN defined:
  - An internal run counter increments on each hit and clears on any miss or timeout.
  - streak_max takes the run value whenever it exceeds it.
  - Both clear when DONE exits.
- Not defined: no streak logic; streak_max is tied to 0.

## Test plan
- Reset, then key_code 3→21 → DRAW. With rand_in = 7, goal_letter = 7 and timer_ctl = 10 one cycle later.
- In PLAY (goal 7), timer at 0/4/2, key_code 21→7 → hits = 1, best = 0/4/2, disp_sel = 0, timer_ctl = 00; then key_code 7→21 → round_num = 1, DRAW.
- In DRAW, rand_in sequence 30, 21, 12 → goal_letter = 12, PLAY entered on the third cycle.
- In PLAY, drive t_s = 5 with no key → misses+1, disp_sel = 2, GAP. Separately, timeout and key 21→goal on the same cycle → counted as a hit.
- With ROUNDS = 2, play hit then wrong key (code 4, goal 9) → after the final keyup, session_done = 1, hits = 1, misses = 1. With ROUND_SEQ_STREAK_EN, streak_max = 1.
- Assert rst during PLAY → all outputs at reset values asynchronously, before the next clk edge.
